// File: rtl/tx_channel_arbiter_pkg.sv
// Shared definitions for the USB gateway TX path: state encodings, default sizes, header magic.
package gateway_pkg;

    localparam int DEF_PACKET_SIZE = 1024;
    localparam int DEF_DATA_W      = 32;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    localparam logic [4:0] ST_IDLE   = 5'b00001;
    localparam logic [4:0] ST_GRANT  = 5'b00010;
    localparam logic [4:0] ST_HEADER = 5'b00100;
    localparam logic [4:0] ST_BURST  = 5'b01000;
    localparam logic [4:0] ST_DRAIN  = 5'b10000;

    typedef enum logic [4:0] {
        IDLE   = ST_IDLE,
        GRANT  = ST_GRANT,
        HEADER = ST_HEADER,
        BURST  = ST_BURST,
        DRAIN  = ST_DRAIN
    } state_t;

endpackage

// File: rtl/tx_channel_arbiter_if.sv
// Source-FIFO read side and TX-FIFO write side of the channel arbiter.
interface tx_channel_arbiter_if #(
    parameter int N_CHAN = 4,
    parameter int DATA_W = 32
);
    logic [N_CHAN-1:0]        src_ready;
    logic [N_CHAN*DATA_W-1:0] src_data;
    logic [N_CHAN-1:0]        src_read;
    logic                     tx_fifo_full;
    logic [DATA_W-1:0]        tx_fifo_data;
    logic                     tx_fifo_write;

    modport master (
        input  src_ready, src_data, tx_fifo_full,
        output src_read, tx_fifo_data, tx_fifo_write
    );

    modport slave (
        output src_ready, src_data, tx_fifo_full,
        input  src_read, tx_fifo_data, tx_fifo_write
    );
endinterface

// File: rtl/tx_channel_arbiter_rr_select.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_select #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] index
);
    int            j;
    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        j     = 0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            cand = IW'(j);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end
endmodule

// File: rtl/tx_channel_arbiter.sv
// Round-robin packet arbiter from N_CHAN source FIFOs into one TX FIFO.
// Define TX_ARB_HEADER_EN to prefix every packet with a one-word channel header.
module tx_channel_arbiter
    import gateway_pkg::*;
#(
    parameter  int N_CHAN      = 4,
    parameter  int PACKET_SIZE = DEF_PACKET_SIZE,
    parameter  int DATA_W      = DEF_DATA_W,
    localparam int CW          = $clog2(N_CHAN),
    localparam int CTR_W       = $clog2(PACKET_SIZE) + 1
) (
    input  logic                 usb_clk,
    input  logic                 rst,
    tx_channel_arbiter_if.master bus,
    output logic [CW-1:0]        cur_chan,
    output logic                 busy
);
    state_t             state, state_nxt;
    logic [CTR_W-1:0]   word_ctr;
    logic [CW-1:0]      rr_ptr;
    logic [CW-1:0]      winner;
    logic               win_vld;
    logic               rd_en;
    logic               hdr_wr;
    logic [N_CHAN-1:0]  src_read_c;
    logic               vld_p0;
    logic               vld_p1;
    logic [DATA_W-1:0]  data_p1;

    rr_select #(.N(N_CHAN)) u_rr_select (
        .req   (bus.src_ready),
        .ptr   (rr_ptr),
        .valid (win_vld),
        .index (winner)
    );

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        hdr_wr    = 1'b0;
        case (state)
            IDLE:  if (|bus.src_ready) state_nxt = GRANT;
`ifdef TX_ARB_HEADER_EN
            GRANT: state_nxt = win_vld ? HEADER : IDLE;
            HEADER: begin
                if (!bus.tx_fifo_full) begin
                    hdr_wr    = 1'b1;
                    state_nxt = BURST;
                end
            end
`else
            GRANT: state_nxt = win_vld ? BURST : IDLE;
`endif
            BURST: begin
                if (word_ctr == CTR_W'(PACKET_SIZE)) state_nxt = DRAIN;
                else if (!bus.tx_fifo_full)           rd_en     = 1'b1;
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        src_read_c           = '0;
        src_read_c[cur_chan] = rd_en;
    end

    assign bus.src_read      = src_read_c;
    assign bus.tx_fifo_write = vld_p1;
    assign bus.tx_fifo_data  = data_p1;
    assign busy              = (state != IDLE);

    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            word_ctr <= '0;
            rr_ptr   <= '0;
            cur_chan <= '0;
        end else begin
            state <= state_nxt;
            if (state == GRANT) begin
                cur_chan <= winner;
                word_ctr <= '0;
            end else if (rd_en) begin
                word_ctr <= word_ctr + 1'b1;
            end
            if (state == DRAIN)
                rr_ptr <= (cur_chan == CW'(N_CHAN - 1)) ? '0 : cur_chan + 1'b1;
        end
    end

    // p0: read issued last cycle, source data now valid
    // p1: registered write toward the TX FIFO
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p0 <= rd_en;
            vld_p1 <= vld_p0 | hdr_wr;
            if (hdr_wr)
                data_p1 <= DATA_W'({HDR_MAGIC, 8'(cur_chan), 16'(PACKET_SIZE)});
            else if (vld_p0)
                data_p1 <= bus.src_data[cur_chan*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_tx_channel_arbiter.sv
// Directed bench for tx_channel_arbiter; also covers the TX_ARB_HEADER_EN build.
module tb_tx_channel_arbiter;
`ifdef TX_ARB_HEADER_EN
    localparam int PS  = 1023;
    localparam int HDR = 1;
`else
    localparam int PS  = 1024;
    localparam int HDR = 0;
`endif
    localparam int PKT = PS + HDR;
    localparam int NC  = 4;

    logic       usb_clk;
    logic       rst;
    logic [1:0] cur_chan;
    logic       busy;

    tx_channel_arbiter_if #(.N_CHAN(NC), .DATA_W(32)) bus ();

    tx_channel_arbiter #(.N_CHAN(NC), .PACKET_SIZE(PS), .DATA_W(32)) dut (
        .usb_clk  (usb_clk),
        .rst      (rst),
        .bus      (bus),
        .cur_chan (cur_chan),
        .busy     (busy)
    );

    initial begin
        usb_clk = 1'b0;
        forever #5 usb_clk = ~usb_clk;
    end

    // Source FIFO model: word = {channel, running sequence}, valid one cycle after read
    int seq [NC];
    always @(posedge usb_clk) begin
        if (rst) begin
            for (int k = 0; k < NC; k++) seq[k] <= 0;
            bus.src_data <= '0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (bus.src_read[k]) begin
                    bus.src_data[k*32 +: 32] <= {8'(k), 24'(seq[k])};
                    seq[k] <= seq[k] + 1;
                end
            end
        end
    end

    // Write capture plus count of writes landing after full has already been seen high
    logic [31:0] wr_mem [8192];
    int          wr_n, ep, max_ep;
    logic        full_d;
    always @(negedge usb_clk) begin
        if (rst) begin
            wr_n   <= 0;
            ep     <= 0;
            max_ep <= 0;
            full_d <= 1'b0;
        end else begin
            full_d <= bus.tx_fifo_full;
            if (bus.tx_fifo_write) begin
                if (wr_n < 8192) wr_mem[wr_n] <= bus.tx_fifo_data;
                wr_n <= wr_n + 1;
            end
            if (!bus.tx_fifo_full) ep <= 0;
            else if (full_d && bus.tx_fifo_write) begin
                ep <= ep + 1;
                if (ep + 1 > max_ep) max_ep <= ep + 1;
            end
        end
    end

    int n_chk, n_pass;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic wait_busy(input logic level, input int limit, input string tag);
        int i = 0;
        while (busy !== level && i < limit) begin cyc(); i++; end
        check(tag, busy, level);
    endtask

    task automatic wait_wr(input int n, input int limit, input string tag);
        int i = 0;
        while (wr_n < n && i < limit) begin cyc(); i++; end
        check(tag, longint'(wr_n >= n), 1);
    endtask

    function automatic int pkt_bad(input int start, input int ch, input int seq0);
        int bad = 0;
`ifdef TX_ARB_HEADER_EN
        if (wr_mem[start] !== {8'hA5, 8'(ch), 16'(PS)}) bad++;
`endif
        for (int i = 0; i < PS; i++)
            if (wr_mem[start + HDR + i] !== {8'(ch), 24'(seq0 + i)}) bad++;
        return bad;
    endfunction

    function automatic int chan_of(input int start);
        logic [31:0] w;
        w = wr_mem[start + HDR];
        return int'(w[31:24]);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_write"}, bus.tx_fifo_write, 0);
        check({tag, "_data"},  bus.tx_fifo_data,  0);
        check({tag, "_read"},  bus.src_read,      0);
        check({tag, "_chan"},  cur_chan,          0);
        check({tag, "_busy"},  busy,              0);
    endtask

    int base;

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        bus.src_ready = '0;
        bus.tx_fifo_full = 1'b0;
        cyc(); cyc();
        check_zero("rst");
        rst = 1'b0;
        cyc();

        // Single channel, no back-pressure
        bus.src_ready = 4'b0001;
        wait_busy(1'b1, 20, "t1_start");
        cyc(); cyc(); cyc();
        bus.src_ready = '0;
        wait_busy(1'b0, 3000, "t1_done");
        cyc(); cyc();
        check("t1_count", wr_n, PKT);
        check("t1_data", pkt_bad(0, 0, 0), 0);
        check("t1_chan", cur_chan, 0);
        check("t1_idle_read", bus.src_read, 0);

        // All channels ready: rotation 0,1,2,3,0
        do_reset();
        bus.src_ready = 4'b1111;
        wait_wr(5 * PKT, 7000, "t2_progress");
        bus.src_ready = '0;
        wait_busy(1'b0, 3000, "t2_done");
        for (int p = 0; p < 5; p++) check($sformatf("t2_chan%0d", p), chan_of(p * PKT), p % 4);
        for (int p = 0; p < 5; p++)
            check($sformatf("t2_data%0d", p), pkt_bad(p * PKT, p % 4, (p == 4) ? PS : 0), 0);
`ifdef TX_ARB_HEADER_EN
        check("t2_hdr_ch3", wr_mem[3 * PKT], 32'hA503_03FF);
`endif

        // Back-pressure toggling every 7 cycles
        do_reset();
        bus.src_ready = 4'b0010;
        begin
            int i = 0;
            bit started = 0;
            while (i < 5000 && !(started && !busy)) begin
                if (i % 7 == 0 && i > 0) bus.tx_fifo_full = ~bus.tx_fifo_full;
                if (busy) started = 1;
                if (i == 12) bus.src_ready = '0;
                cyc();
                i++;
            end
            check("t3_done", longint'(started && !busy), 1);
        end
        bus.tx_fifo_full = 1'b0;
        cyc(); cyc();
        check("t3_count", wr_n, PKT);
        check("t3_data", pkt_bad(0, 1, 0), 0);
        check("t3_late_writes", max_ep, 1);

        // Fairness: ch1 raised while ch2 holds the grant
        do_reset();
        bus.src_ready = 4'b0100;
        wait_busy(1'b1, 20, "t4_start");
        repeat (100) cyc();
        bus.src_ready = 4'b0110;
        wait_wr(3 * PKT, 4000, "t4_progress");
        bus.src_ready = '0;
        wait_busy(1'b0, 3000, "t4_done");
        check("t4_chan0", chan_of(0), 2);
        check("t4_chan1", chan_of(PKT), 1);
        check("t4_chan2", chan_of(2 * PKT), 2);
        check("t4_data1", pkt_bad(PKT, 1, 0), 0);

        // Reset mid-packet; round-robin pointer was left at 3 by the previous test
        cyc(); cyc();
        base = wr_n;
        bus.src_ready = 4'b1000;
        wait_wr(base + 500, 2000, "t5_progress");
        bus.src_ready = 4'b1001;
        rst = 1'b1;
        #1;
        check_zero("t5_async");
        cyc(); cyc();
        rst = 1'b0;
        wait_busy(1'b1, 20, "t5_start");
        cyc(); cyc(); cyc();
        bus.src_ready = '0;
        wait_busy(1'b0, 3000, "t5_done");
        cyc(); cyc();
        check("t5_count", wr_n, PKT);
        check("t5_chan", cur_chan, 0);
        check("t5_data", pkt_bad(0, 0, 0), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
